// File: rtl/mul_seq.sv
// mul_seq: 16x16 unsigned shift-add multiplier that borrows the shared execute ALU for one add per cycle.
// Latency 17 cycles from the start-accept edge to done; stall is held from the issue cycle until done.
module mul_seq #(
    parameter int          WIDTH    = 16,
    parameter logic [3:0]  ADD_OPER = 4'b0100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_cf,
    output logic [WIDTH-1:0] alu_InA,
    output logic [WIDTH-1:0] alu_InB,
    output logic [3:0]       alu_Oper,
    output logic             alu_own,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] prod_hi,
    output logic [WIDTH-1:0] prod_lo
);

    localparam int            CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [CW-1:0]    cnt;
    logic             accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        stall     = 1'b0;
        done      = 1'b0;
        alu_own   = 1'b0;
        alu_InA   = '0;
        alu_InB   = '0;
        alu_Oper  = '0;
        case (state)
            IDLE: begin
                stall  = start;
                accept = start;
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                stall    = 1'b1;
                alu_own  = 1'b1;
                alu_Oper = ADD_OPER;
                alu_InA  = hi;
                alu_InB  = lo[0] ? m : '0;
                if (cnt == LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                stall     = start;
                accept    = start;
                state_nxt = start ? RUN : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // The ALU carry becomes the new MSB of hi; the bit shifted out of the sum enters lo from the top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m   <= '0;
            hi  <= '0;
            lo  <= '0;
            cnt <= '0;
        end else if (accept) begin
            m   <= opA;
            hi  <= '0;
            lo  <= opB;
            cnt <= '0;
        end else if (state == RUN) begin
            hi  <= {alu_cf, alu_out[WIDTH-1:1]};
            lo  <= {alu_out[0], lo[WIDTH-1:1]};
            cnt <= cnt + 1'b1;
        end
    end

    assign prod_hi = hi;
    assign prod_lo = lo;

endmodule

// File: tb/tb_mul_seq.sv
// Directed bench for mul_seq with a combinational add model standing in for the shared ALU.
module tb_mul_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] opA;
    logic [15:0] opB;
    logic [15:0] alu_out;
    logic        alu_cf;
    logic [15:0] alu_InA;
    logic [15:0] alu_InB;
    logic [3:0]  alu_Oper;
    logic        alu_own;
    logic        stall;
    logic        done;
    logic [15:0] prod_hi;
    logic [15:0] prod_lo;
    logic [16:0] sum;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] sb[$];

    mul_seq #(.WIDTH(16), .ADD_OPER(4'b0100)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .opA      (opA),
        .opB      (opB),
        .alu_out  (alu_out),
        .alu_cf   (alu_cf),
        .alu_InA  (alu_InA),
        .alu_InB  (alu_InB),
        .alu_Oper (alu_Oper),
        .alu_own  (alu_own),
        .stall    (stall),
        .done     (done),
        .prod_hi  (prod_hi),
        .prod_lo  (prod_lo)
    );

    assign sum     = {1'b0, alu_InA} + {1'b0, alu_InB};
    assign alu_out = sum[15:0];
    assign alu_cf  = sum[16];

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        vectors++;
        assert (obs === want) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, want);
        end
    endtask

    // Called at a falling edge in IDLE or DONE; the following rising edge accepts.
    task automatic issue(input logic [15:0] a, input logic [15:0] b);
        start = 1'b1;
        opA   = a;
        opB   = b;
        sb.push_back(32'(a) * 32'(b));
        #1 check("stall_at_issue", 32'(stall), 32'd1);
    endtask

    // Counts falling edges from the accept edge until done; optionally pulses start mid-run
    // or keeps start high into DONE with new operands for a back-to-back multiply.
    task automatic wait_done(input string tag, input int pulse_at, input bit hold_start,
                             input logic [15:0] na, input logic [15:0] nb);
        int          n   = 0;
        int          bad = 0;
        bit          got = 1'b0;
        logic [31:0] want;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) begin
                got = 1'b1;
            end else if (stall !== 1'b1 || alu_own !== 1'b1 || alu_Oper !== 4'b0100) begin
                bad++;
            end
            if (n == 1) begin
                if (hold_start) begin
                    opA = na;
                    opB = nb;
                    sb.push_back(32'(na) * 32'(nb));
                end else begin
                    start = 1'b0;
                end
            end
            if (pulse_at > 0 && n == pulse_at) begin
                start = 1'b1;
                opA   = 16'd2;
                opB   = 16'd2;
            end
            if (pulse_at > 0 && n == pulse_at + 1) begin
                start = 1'b0;
            end
        end
        check({tag, "_latency"}, 32'(n), 32'd17);
        check({tag, "_run_cycles_bad"}, 32'(bad), 32'd0);
        if (got) begin
            want = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
            check({tag, "_product"}, {prod_hi, prod_lo}, want);
            check({tag, "_stall_at_done"}, 32'(stall), 32'(hold_start));
            check({tag, "_own_oper_at_done"}, 32'({alu_own, alu_Oper}), 32'd0);
            check({tag, "_alu_ops_at_done"}, {alu_InA, alu_InB}, 32'd0);
        end
    endtask

    initial begin
        int dbad;
        rst_n = 1'b1;
        start = 1'b0;
        opA   = '0;
        opB   = '0;

        #2 rst_n = 1'b0;
        #1;
        check("rst_done", 32'(done), 32'd0);
        check("rst_own", 32'(alu_own), 32'd0);
        check("rst_prod", {prod_hi, prod_lo}, 32'd0);
        check("rst_alu_ops", {alu_InA, alu_InB}, 32'd0);
        check("rst_alu_oper", 32'(alu_Oper), 32'd0);
        check("rst_stall_idle", 32'(stall), 32'd0);
        start = 1'b1;
        #1 check("rst_stall_follows_start", 32'(stall), 32'd1);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_done_clocked", 32'(done), 32'd0);
        rst_n = 1'b1;

        @(negedge clk);
        issue(16'd3, 16'd5);
        wait_done("m3x5", 0, 1'b0, 16'd0, 16'd0);
        @(negedge clk);
        check("m3x5_done_single", 32'(done), 32'd0);
        check("m3x5_prod_held", {prod_hi, prod_lo}, 32'h0000_000F);
        check("m3x5_stall_idle", 32'(stall), 32'd0);

        issue(16'hFFFF, 16'hFFFF);
        wait_done("mffff", 0, 1'b0, 16'd0, 16'd0);
        @(negedge clk);
        issue(16'h1234, 16'h0010);
        wait_done("m1234x10", 0, 1'b0, 16'd0, 16'd0);
        @(negedge clk);
        issue(16'h1234, 16'h0000);
        wait_done("m1234x0", 0, 1'b0, 16'd0, 16'd0);

        @(negedge clk);
        issue(16'd7, 16'd9);
        wait_done("ignore_start", 5, 1'b0, 16'd0, 16'd0);

        @(negedge clk);
        issue(16'd6, 16'd7);
        wait_done("b2b_first", 0, 1'b1, 16'd10, 16'd10);
        wait_done("b2b_second", 0, 1'b0, 16'd0, 16'd0);

        @(negedge clk);
        start = 1'b1;
        opA   = 16'hFFFF;
        opB   = 16'hFFFF;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_prod", {prod_hi, prod_lo}, 32'd0);
        check("abort_own_oper", 32'({alu_own, alu_Oper}), 32'd0);
        check("abort_alu_ops", {alu_InA, alu_InB}, 32'd0);
        check("abort_stall", 32'(stall), 32'd0);
        dbad = 0;
        repeat (3) begin
            @(negedge clk);
            if (done !== 1'b0) dbad++;
        end
        check("abort_no_done", 32'(dbad), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        issue(16'd4, 16'd4);
        wait_done("after_abort", 0, 1'b0, 16'd0, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
